modular_operand_stage: RTL
==========================

Name: modular_operand_stage

Overview:
- Pipelined operand stage directly upstream of the correction/selection stage of the modular adder/subtractor.
- Accepts operands a and b, modulus m, and operation select s over a valid/ready handshake.
- Registers the raw sum or difference v, the modulus-adjusted value w, and the borrow/carry flags b4_0 and b4 that the downstream stage uses to choose between v and w.
- Also flags out-of-range operands and keeps a saturating error count.

Parameters:
- WIDTH, 4, operand and modulus width in bits.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has an operand set.
- in_ready  output  1  stage can accept an operand set this cycle.
- s  input  1  0 = add (a+b mod m), 1 = subtract (a-b mod m).
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- m  input  WIDTH  modulus, unsigned.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts the result.
- s_o  output  1  registered s.
- v  output  WIDTH+1  raw result; v[WIDTH] is carry (add) or borrow (sub).
- w  output  WIDTH+1  adjusted result; w[WIDTH] is borrow (add) or carry (sub).
- b4_0  output  1  low-part flag (defined below).
- b4  output  1  full-width flag (defined below).
- err  output  1  result belongs to an invalid operand set.
- err_cnt  output  ERR_CNT_W  saturating count of accepted invalid sets.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid=0, skid buffer empty, in_ready=1 once rst_n is high.
  - s_o, v, w, b4_0, b4, err all 0; err_cnt=0.
  - Reset mid-transfer discards all held data.
- Arithmetic, all unsigned with no truncation before flag extraction:
  - Add (s=0):
    - v = a+b, WIDTH+1 bits.
    - w = (v - m) mod 2^(WIDTH+1).
    - b4_0 = borrow out of v[WIDTH-1:0] - m.
    - b4 = borrow out of the full (WIDTH+1)-bit v - m.
  - Subtract (s=1):
    - v = (a - b) mod 2^(WIDTH+1); v[WIDTH] = borrow.
    - w = v[WIDTH-1:0] + m, WIDTH+1 bits.
    - b4_0 = carry out of v[WIDTH-1:0] + m.
    - b4 = v[WIDTH].
- Error flag: err = (m==0) | (a>=m) | (b>=m). The result fields are still computed and passed through unchanged.
- Handshake:
  - A transfer in occurs when in_valid & in_ready; a transfer out occurs when out_valid & out_ready.
  - Latency: an accepted set appears on the outputs on the next rising edge when the output register is empty or draining in the same cycle.
  - Output register plus one-entry skid buffer: in_ready = !skid_full, which is a registered signal (no combinational path from out_ready).
  - Output stalled and a new set accepted: the new set goes into the skid buffer and in_ready drops next cycle.
  - Skid full and out_ready high: the skid entry moves to the output register and in_ready rises next cycle.
  - Simultaneous accept and drain with an empty skid: the output register loads the new set directly, with no bubble.
  - Output fields are held stable while out_valid & !out_ready.
  - in_valid with in_ready low: no state change. Upstream holds its data.
  - Order is strictly preserved; no set is dropped or duplicated.
- err_cnt:
  - Increments by 1 on each input transfer with err=1.
  - Saturates at 2^ERR_CNT_W-1.
  - Cleared only by reset.

Decomposition:
- Shared package/header holds:
  - the WIDTH default;
  - the op encoding constants OP_ADD=0 and OP_SUB=1;
  - the packed result-bundle layout {s_o, err, b4, b4_0, w, v}, used by both the output register and the skid entry.
- One natural sub-module: modular_operand_calc, purely combinational.
  - Inputs: s, a, b, m.
  - Outputs: v, w, b4_0, b4, err.
  - The top module wraps it with the handshake registers and the counter.

Test Plan:
- m=13, s=0, a=9, b=7, out_ready=1 -> next cycle: v=5'b10000, w=5'b00011, b4_0=1, b4=0, err=0, out_valid=1.
- m=13, s=0, a=2, b=3 -> v=5'b00101, w=5'b11000, b4_0=1, b4=1, err=0.
- m=13, s=1, a=3, b=7 -> v=5'b11100, w=5'b11001, b4_0=1, b4=1, err=0 (downstream selects 9).
- Backpressure: out_ready=0 and three back-to-back sets offered -> first set held on the outputs, second set in the skid buffer, in_ready=0 from the cycle after the second accept. Then out_ready=1 -> sets emerge in order, and in_ready returns 1 one cycle after the skid drains.
- Error path: m=0 with any a, b; then m=5, a=7 -> both results have err=1 and err_cnt=2. With ERR_CNT_W=2, six invalid sets -> err_cnt saturates at 3.
- Drive rst_n low while out_valid=1 and the skid buffer is full -> out_valid=0, in_ready=1, err_cnt=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/modular_operand_stage_pkg.sv
// Shared constants and result-bundle layout for the modular operand stage.
// The bundle is packed MSB-first as {s_o, err, b4, b4_0, w, v}.
package modular_operand_stage_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Flag bit offsets above the flags base of the bundle
    localparam int F_B4_0 = 0;
    localparam int F_B4   = 1;
    localparam int F_ERR  = 2;
    localparam int F_S    = 3;

    function automatic int bundle_width(input int width);
        return 2 * (width + 1) + 4;
    endfunction

    function automatic int w_lsb(input int width);
        return width + 1;
    endfunction

    function automatic int flags_lsb(input int width);
        return 2 * (width + 1);
    endfunction

endpackage

// File: rtl/modular_operand_stage_if.sv
// Operand-in / result-out bus of the modular operand stage.
// master = environment (drives operands, out_ready); slave = the stage.
interface modular_operand_stage_if
    import modular_operand_stage_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 s;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     m;
    logic                 out_valid;
    logic                 out_ready;
    logic                 s_o;
    logic [WIDTH:0]       v;
    logic [WIDTH:0]       w;
    logic                 b4_0;
    logic                 b4;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, s, a, b, m, out_ready,
        input  in_ready, out_valid, s_o, v, w, b4_0, b4, err, err_cnt
    );

    modport slave (
        input  in_valid, s, a, b, m, out_ready,
        output in_ready, out_valid, s_o, v, w, b4_0, b4, err, err_cnt
    );
endinterface

// File: rtl/modular_operand_calc.sv
// Combinational core: raw result v, modulus-adjusted w, selection flags
// and operand range check for one modular add/subtract.
module modular_operand_calc
    import modular_operand_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   v,
    output logic [WIDTH:0]   w,
    output logic             b4_0,
    output logic             b4,
    output logic             err
);
    logic [WIDTH:0]   sum_ab;
    logic [WIDTH:0]   dif_ab;
    logic [WIDTH+1:0] full_sub;
    logic [WIDTH:0]   low_sub;
    logic [WIDTH:0]   low_add;

    // One extra bit on every intermediate so borrows/carries survive to the flags
    always_comb begin
        sum_ab   = {1'b0, a} + {1'b0, b};
        dif_ab   = {1'b0, a} - {1'b0, b};
        full_sub = {1'b0, sum_ab} - {2'b00, m};
        low_sub  = {1'b0, sum_ab[WIDTH-1:0]} - {1'b0, m};
        low_add  = {1'b0, dif_ab[WIDTH-1:0]} + {1'b0, m};

        v    = sum_ab;
        w    = full_sub[WIDTH:0];
        b4_0 = low_sub[WIDTH];
        b4   = full_sub[WIDTH+1];
        if (s != OP_ADD) begin
            v    = dif_ab;
            w    = low_add;
            b4_0 = low_add[WIDTH];
            b4   = dif_ab[WIDTH];
        end

        err = (m == '0) | (a >= m) | (b >= m);
    end
endmodule

// File: rtl/modular_operand_stage.sv
// Registered operand stage: modular_operand_calc behind an output register
// with a one-entry skid buffer, plus a saturating invalid-operand counter.
module modular_operand_stage
    import modular_operand_stage_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    modular_operand_stage_if.slave bus
);
    localparam int BW  = bundle_width(WIDTH);
    localparam int WL  = w_lsb(WIDTH);
    localparam int FL  = flags_lsb(WIDTH);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH:0]       calc_v;
    logic [WIDTH:0]       calc_w;
    logic                 calc_b4_0;
    logic                 calc_b4;
    logic                 calc_err;
    logic [BW-1:0]        new_res;

    logic [BW-1:0]        out_reg,  out_next;
    logic                 out_valid_reg, out_valid_next;
    logic [BW-1:0]        skid_reg, skid_next;
    logic                 skid_full_reg, skid_full_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;

    logic                 accept;
    logic                 drain;

    modular_operand_calc #(.WIDTH(WIDTH)) u_calc (
        .s    (bus.s),
        .a    (bus.a),
        .b    (bus.b),
        .m    (bus.m),
        .v    (calc_v),
        .w    (calc_w),
        .b4_0 (calc_b4_0),
        .b4   (calc_b4),
        .err  (calc_err)
    );

    assign new_res = {bus.s, calc_err, calc_b4, calc_b4_0, calc_w, calc_v};

    // in_ready depends only on registered state, never on out_ready
    assign bus.in_ready = !skid_full_reg;
    assign accept       = bus.in_valid & !skid_full_reg;
    assign drain        = out_valid_reg & bus.out_ready;

    always_comb begin
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        skid_next      = skid_reg;
        skid_full_next = skid_full_reg;
        err_cnt_next   = err_cnt_reg;

        if (!out_valid_reg || drain) begin
            // Skid entry is older than anything arriving now, so it goes first
            if (skid_full_reg) begin
                out_next       = skid_reg;
                out_valid_next = 1'b1;
                skid_full_next = 1'b0;
            end else if (accept) begin
                out_next       = new_res;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_next      = new_res;
            skid_full_next = 1'b1;
        end

        if (accept && calc_err && (err_cnt_reg != CNT_MAX)) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            skid_reg      <= '0;
            skid_full_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            skid_reg      <= skid_next;
            skid_full_reg <= skid_full_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.v         = out_reg[WIDTH:0];
    assign bus.w         = out_reg[WL +: WIDTH+1];
    assign bus.b4_0      = out_reg[FL + F_B4_0];
    assign bus.b4        = out_reg[FL + F_B4];
    assign bus.err       = out_reg[FL + F_ERR];
    assign bus.s_o       = out_reg[FL + F_S];
    assign bus.err_cnt   = err_cnt_reg;
endmodule
